vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
Shares a single external asynchronous VRAM between the MPU port and the Renderer. It replaces the combinational "MPU always wins" multiplexing with a sequenced access controller: it arbitrates, generates SRAM setup/strobe/hold timing, captures read data, and acknowledges each requester. Renderer gets priority for display timing, with a bounded-starvation guarantee for the MPU. It sits between the ChronoCube top level, the Renderer VRAM bus and the VRAM pins; the top level owns the tri-state buffer.

Parameters:
ADDR_WIDTH, 16, VRAM word address width
DATA_WIDTH, 16, VRAM data width
ACCESS_CYCLES, 2, strobe length N in clocks (1..15)
REN_BURST_MAX, 8, consecutive renderer grants allowed while MPU waits (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mpu_req  in  1  MPU access request, level, held until mpu_ack
mpu_wr  in  1  1 = write, 0 = read
mpu_be  in  2  byte enables, active high
mpu_addr  in  ADDR_WIDTH  MPU address
mpu_wdata  in  DATA_WIDTH  MPU write data
mpu_rdata  out  DATA_WIDTH  MPU read data, valid while mpu_ack=1, held afterwards
mpu_ack  out  1  one-cycle completion pulse
ren_req  in  1  renderer read request, level, held until ren_ack
ren_addr  in  ADDR_WIDTH  renderer address
ren_rdata  out  DATA_WIDTH  renderer read data, valid while ren_ack=1, held afterwards
ren_ack  out  1  one-cycle completion pulse
_vram_en  out  1  chip enable, active low
_vram_rd  out  1  output enable, active low
_vram_wr  out  1  write enable, active low
_vram_be  out  2  byte enables, active low
vram_addr  out  ADDR_WIDTH  VRAM address
vram_data_out  out  DATA_WIDTH  write data to pad
vram_data_oe  out  1  1 = top level drives vram_data_out onto the pad
vram_data_in  in  DATA_WIDTH  pad read data

Behaviour:
- All outputs are registered. Reset values: _vram_en/_vram_rd/_vram_wr=1, _vram_be=2'b11, vram_addr=0, vram_data_out=0, oe=0, both acks=0, both rdata=0, starve counter=0, state=IDLE.
- States are IDLE, SETUP, STROBE, HOLD.
- IDLE: bus is idle. If any request is present, grant one and latch its addr, wr, be and wdata. Renderer accesses are always reads with be=2'b11. Next state is SETUP.
- Arbitration in IDLE:
  - Only one request present: grant it.
  - Both present: grant the renderer unless starve_cnt >= REN_BURST_MAX; in that case grant the MPU.
  - starve_cnt increments on each renderer grant while mpu_req=1.
  - starve_cnt clears on an MPU grant, and on any cycle where mpu_req=0.
- SETUP (1 cycle): _vram_en=0 and addr/be are driven. For a write, oe=1 with data driven. Strobes stay high.
- STROBE (N cycles): _vram_rd=0 for a read, or _vram_wr=0 for a write. On the last STROBE cycle, register vram_data_in into the granted requester's rdata.
- HOLD (1 cycle): strobes return high. _vram_en, addr and data stay driven (write data hold). The granted requester's ack=1. Next state is IDLE, with everything deasserted.
- Latency: a request sampled in IDLE at cycle 0 gets its ack at cycle N+2. A new grant earliest at cycle N+3, so throughput is one access per N+3 cycles.
- Requesters must drop req on the edge after they see ack. A req still high in the following IDLE is treated as a new request.
- Request inputs are ignored outside IDLE; changing addr/data after grant has no effect.
- A synchronous reset in any state aborts the access: next cycle all outputs are at reset values, and no ack is issued for the aborted transfer.
- _vram_rd and _vram_wr are never low in the same cycle. oe is 1 only during write SETUP/STROBE/HOLD.

Optional Feature:
VRAM_ARB_STATS_EN:
- Defined: adds output stat_mpu_stall [15:0], a saturating count (stops at 16'hFFFF) of cycles where mpu_req=1 and mpu_ack=0. Cleared by reset.
- Undefined: stat_mpu_stall is tied to 0 and no counter logic exists.

Test Plan:
- MPU write, addr 0x0123, data 0xBEEF, be 2'b11, N=2 -> cycle1 _vram_en=0, vram_addr=0x0123, oe=1; cycles 2-3 _vram_wr=0; cycle4 mpu_ack=1 with _vram_wr=1 and data still 0xBEEF; cycle5 all idle.
- Renderer read of 0x0040, model returns 0x1234 -> _vram_rd=0 cycles 2-3, oe=0 throughout, ren_ack=1 at cycle4 with ren_rdata=0x1234.
- Both requests at cycle0 -> renderer acked at cycle4, MPU granted at cycle5 and acked at cycle9; no cycle has both strobes low.
- REN_BURST_MAX=8, ren_req and mpu_req held continuously -> exactly 8 ren_acks, then one mpu_ack, then the renderer resumes; pattern repeats.
- MPU byte write with be=2'b01 -> _vram_be=2'b10 in cycles 1-4.
- Reset asserted during the second STROBE cycle -> next cycle strobes=1, oe=0, no ack; a fresh request afterwards completes in N+2 cycles. With VRAM_ARB_STATS_EN, stat_mpu_stall=0 after reset.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: sequences MPU and renderer accesses onto one async VRAM.
// Ports: mpu_* (rd/wr, ack), ren_* (read, ack), _vram_*/vram_* pad side.
// All outputs are registered.
// Optional macro VRAM_ARB_STATS_EN adds the stat_mpu_stall counter.
// Without it, stat_mpu_stall is tied to zero.
module vram_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int REN_BURST_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mpu_req,
  input  logic                  mpu_wr,
  input  logic [1:0]            mpu_be,
  input  logic [ADDR_WIDTH-1:0] mpu_addr,
  input  logic [DATA_WIDTH-1:0] mpu_wdata,
  output logic [DATA_WIDTH-1:0] mpu_rdata,
  output logic                  mpu_ack,
  input  logic                  ren_req,
  input  logic [ADDR_WIDTH-1:0] ren_addr,
  output logic [DATA_WIDTH-1:0] ren_rdata,
  output logic                  ren_ack,
  output logic                  _vram_en,
  output logic                  _vram_rd,
  output logic                  _vram_wr,
  output logic [1:0]            _vram_be,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0] vram_data_out,
  output logic                  vram_data_oe,
  input  logic [DATA_WIDTH-1:0] vram_data_in,
  output logic [15:0]           stat_mpu_stall
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [3:0] LAST  = 4'(ACCESS_CYCLES - 1);
  localparam logic [7:0] BURST = 8'(REN_BURST_MAX);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            starve_q, starve_d;
  logic                  sel_ren_q, sel_ren_d;
  logic                  wr_q, wr_d;
  logic [1:0]            be_q, be_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  en_n_q, en_n_d;
  logic                  rd_n_q, rd_n_d;
  logic                  wr_n_q, wr_n_d;
  logic [1:0]            be_n_q, be_n_d;
  logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic                  mack_q, mack_d;
  logic                  rack_q, rack_d;
  logic [DATA_WIDTH-1:0] mrdata_q, mrdata_d;
  logic [DATA_WIDTH-1:0] rrdata_q, rrdata_d;

  logic ren_win, mpu_win;

  // Renderer wins ties until the MPU has waited out a full burst.
  always_comb begin
    ren_win = ren_req && !(mpu_req && (starve_q >= BURST));
    mpu_win = mpu_req && !ren_win;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    sel_ren_d = sel_ren_q;
    wr_d      = wr_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mrdata_d  = mrdata_q;
    rrdata_d  = rrdata_q;

    if (!mpu_req) starve_d = '0;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          ren_win: begin
            state_d   = SETUP;
            sel_ren_d = 1'b1;
            wr_d      = 1'b0;
            be_d      = 2'b11;
            addr_d    = ren_addr;
            wdata_d   = '0;
            if (mpu_req) starve_d = starve_q + 8'd1;
          end
          mpu_win: begin
            state_d   = SETUP;
            sel_ren_d = 1'b0;
            wr_d      = mpu_wr;
            be_d      = mpu_be;
            addr_d    = mpu_addr;
            wdata_d   = mpu_wdata;
            starve_d  = '0;
          end
          default: ;
        endcase
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: begin
        if (cnt_q == LAST) begin
          state_d = HOLD;
          // Only reads capture pad data; a write leaves rdata held.
          if (!wr_q) begin
            if (sel_ren_q) rrdata_d = vram_data_in;
            else           mrdata_d = vram_data_in;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pad outputs are a pure function of the next state and latched request.
  always_comb begin
    en_n_d = 1'b1;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    be_n_d = 2'b11;
    vaddr_d = '0;
    dout_d = '0;
    oe_d   = 1'b0;
    mack_d = 1'b0;
    rack_d = 1'b0;
    if (state_d != IDLE) begin
      en_n_d  = 1'b0;
      vaddr_d = addr_d;
      be_n_d  = ~be_d;
      if (wr_d) begin
        oe_d   = 1'b1;
        dout_d = wdata_d;
      end
    end
    if (state_d == STROBE) begin
      rd_n_d = wr_d;
      wr_n_d = ~wr_d;
    end
    if (state_d == HOLD) begin
      mack_d = ~sel_ren_d;
      rack_d = sel_ren_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      starve_q  <= '0;
      sel_ren_q <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      en_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      be_n_q    <= 2'b11;
      vaddr_q   <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      mack_q    <= 1'b0;
      rack_q    <= 1'b0;
      mrdata_q  <= '0;
      rrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      sel_ren_q <= sel_ren_d;
      wr_q      <= wr_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      en_n_q    <= en_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      be_n_q    <= be_n_d;
      vaddr_q   <= vaddr_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      mack_q    <= mack_d;
      rack_q    <= rack_d;
      mrdata_q  <= mrdata_d;
      rrdata_q  <= rrdata_d;
    end
  end

  assign _vram_en      = en_n_q;
  assign _vram_rd      = rd_n_q;
  assign _vram_wr      = wr_n_q;
  assign _vram_be      = be_n_q;
  assign vram_addr     = vaddr_q;
  assign vram_data_out = dout_q;
  assign vram_data_oe  = oe_q;
  assign mpu_ack       = mack_q;
  assign ren_ack       = rack_q;
  assign mpu_rdata     = mrdata_q;
  assign ren_rdata     = rrdata_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (mpu_req && !mack_q && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stat_mpu_stall = stall_q;
`else
  assign stat_mpu_stall = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vectors and multi-cycle sequences
// for vram_arbiter with default parameters (N=2, burst 8).
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mpu_req, mpu_wr;
  logic [1:0]  mpu_be;
  logic [15:0] mpu_addr, mpu_wdata, mpu_rdata;
  logic        mpu_ack;
  logic        ren_req;
  logic [15:0] ren_addr, ren_rdata;
  logic        ren_ack;
  logic        _vram_en, _vram_rd, _vram_wr;
  logic [1:0]  _vram_be;
  logic [15:0] vram_addr, vram_data_out, vram_data_in;
  logic        vram_data_oe;
  logic [15:0] stat_mpu_stall;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .mpu_req       (mpu_req),
    .mpu_wr        (mpu_wr),
    .mpu_be        (mpu_be),
    .mpu_addr      (mpu_addr),
    .mpu_wdata     (mpu_wdata),
    .mpu_rdata     (mpu_rdata),
    .mpu_ack       (mpu_ack),
    .ren_req       (ren_req),
    .ren_addr      (ren_addr),
    .ren_rdata     (ren_rdata),
    .ren_ack       (ren_ack),
    ._vram_en      (_vram_en),
    ._vram_rd      (_vram_rd),
    ._vram_wr      (_vram_wr),
    ._vram_be      (_vram_be),
    .vram_addr     (vram_addr),
    .vram_data_out (vram_data_out),
    .vram_data_oe  (vram_data_oe),
    .vram_data_in  (vram_data_in),
    .stat_mpu_stall(stat_mpu_stall)
  );

  // VRAM model: 0x0040 holds 0x1234, others return addr ^ 0x5A5A.
  function automatic logic [15:0] mem(input logic [15:0] a);
    return (a == 16'h0040) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  assign vram_data_in = !_vram_rd ? mem(vram_addr) : 16'hDEAD;

  typedef struct packed {
    logic        rst, mreq, mwr;
    logic [1:0]  mbe;
    logic [15:0] maddr, mwd;
    logic        rreq;
    logic [15:0] raddr;
  } stim_t;

  typedef struct packed {
    logic        en, rd, wr;
    logic [1:0]  be;
    logic        oe, ma, ra;
    logic [15:0] ad, d, mr, rr;
  } obs_t;

  typedef struct {
    string name;
    stim_t s;
    obs_t  e;
    bit    cs;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic stim_t S(bit r, bit mq, bit mw, logic [1:0] be,
                              logic [15:0] ma, logic [15:0] md,
                              bit rq, logic [15:0] ra);
    stim_t x;
    x = '{r, mq, mw, be, ma, md, rq, ra};
    return x;
  endfunction

  function automatic obs_t O(bit en, bit rd, bit wr, logic [1:0] be,
                             bit oe, bit ma, bit ra, logic [15:0] ad,
                             logic [15:0] d, logic [15:0] mr,
                             logic [15:0] rr);
    obs_t x;
    x = '{en, rd, wr, be, oe, ma, ra, ad, d, mr, rr};
    return x;
  endfunction

  function automatic obs_t I(logic [15:0] mr, logic [15:0] rr);
    return O(1, 1, 1, 2'b11, 0, 0, 0, 16'h0, 16'h0, mr, rr);
  endfunction

  function automatic void add(string n, stim_t s, obs_t e, bit cs = 0);
    vec_t v;
    v.name = n;
    v.s = s;
    v.e = e;
    v.cs = cs;
    tbl.push_back(v);
  endfunction

  function automatic obs_t grab();
    obs_t g;
    g = '{_vram_en, _vram_rd, _vram_wr, _vram_be, vram_data_oe,
          mpu_ack, ren_ack, vram_addr, vram_data_out,
          mpu_rdata, ren_rdata};
    return g;
  endfunction

  task automatic drive(stim_t s);
    reset     = s.rst;
    mpu_req   = s.mreq;
    mpu_wr    = s.mwr;
    mpu_be    = s.mbe;
    mpu_addr  = s.maddr;
    mpu_wdata = s.mwd;
    ren_req   = s.rreq;
    ren_addr  = s.raddr;
  endtask

  task automatic chk(string n, obs_t e);
    obs_t g;
    g = grab();
    nvec++;
    if (g !== e) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", n, g, e);
    end
  endtask

  task automatic ren_seq(string p, logic [15:0] mr);
    stim_t r;
    r = S(0, 0, 0, 2'b00, 16'h0, 16'h0, 1, 16'h0040);
    add({p, "_setup"}, r, O(0,1,1,2'b00,0,0,0,16'h0040,16'h0,mr,16'h0));
    add({p, "_stb1"}, r, O(0,0,1,2'b00,0,0,0,16'h0040,16'h0,mr,16'h0));
    add({p, "_stb2"}, r, O(0,0,1,2'b00,0,0,0,16'h0040,16'h0,mr,16'h0));
    add({p, "_hold"}, r, O(0,1,1,2'b00,0,0,1,16'h0040,16'h0,mr,16'h1234));
    add({p, "_done"}, r, I(mr, 16'h1234));
  endtask

  task automatic build();
    stim_t q, w, w2, b, m, bb, mo, rw;
    q  = S(0, 0, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
    w  = S(0, 1, 1, 2'b11, 16'h0123, 16'hBEEF, 0, 16'h0);
    w2 = S(0, 1, 1, 2'b11, 16'hFFFF, 16'h0000, 0, 16'h0);
    b  = S(0, 1, 1, 2'b01, 16'h0200, 16'h00AA, 0, 16'h0);
    m  = S(0, 1, 0, 2'b11, 16'h0077, 16'h0, 0, 16'h0);
    bb = S(0, 1, 0, 2'b11, 16'h0010, 16'h0, 1, 16'h0041);
    mo = S(0, 1, 0, 2'b11, 16'h0010, 16'h0, 0, 16'h0);
    rw = S(1, 1, 1, 2'b11, 16'h0123, 16'hBEEF, 0, 16'h0);

    add("reset", S(1,0,0,2'b00,16'h0,16'h0,0,16'h0), I(0, 0), 1);
    add("idle", q, I(0, 0));

    add("wr_setup", w,  O(0,1,1,2'b00,1,0,0,16'h0123,16'hBEEF,0,0));
    add("wr_stb1",  w2, O(0,1,0,2'b00,1,0,0,16'h0123,16'hBEEF,0,0));
    add("wr_stb2",  w2, O(0,1,0,2'b00,1,0,0,16'h0123,16'hBEEF,0,0));
    add("wr_hold",  w,  O(0,1,1,2'b00,1,1,0,16'h0123,16'hBEEF,0,0));
    add("wr_done",  w,  I(0, 0));
    add("wr_idle",  q,  I(0, 0));

    ren_seq("rd", 16'h0);
    add("rd_idle", q, I(0, 16'h1234));

    add("be_setup", b, O(0,1,1,2'b10,1,0,0,16'h0200,16'h00AA,0,16'h1234));
    add("be_stb1",  b, O(0,1,0,2'b10,1,0,0,16'h0200,16'h00AA,0,16'h1234));
    add("be_stb2",  b, O(0,1,0,2'b10,1,0,0,16'h0200,16'h00AA,0,16'h1234));
    add("be_hold",  b, O(0,1,1,2'b10,1,1,0,16'h0200,16'h00AA,0,16'h1234));
    add("be_done",  b, I(0, 16'h1234));
    add("be_idle",  q, I(0, 16'h1234));

    add("mr_setup", m, O(0,1,1,2'b00,0,0,0,16'h0077,16'h0,0,16'h1234));
    add("mr_stb1",  m, O(0,0,1,2'b00,0,0,0,16'h0077,16'h0,0,16'h1234));
    add("mr_stb2",  m, O(0,0,1,2'b00,0,0,0,16'h0077,16'h0,0,16'h1234));
    add("mr_hold",  m, O(0,1,1,2'b00,0,1,0,16'h0077,16'h0,16'h5A2D,16'h1234));
    add("mr_done",  m, I(16'h5A2D, 16'h1234));
    add("mr_idle",  q, I(16'h5A2D, 16'h1234));

    add("both_r_setup", bb, O(0,1,1,2'b00,0,0,0,16'h0041,16'h0,16'h5A2D,16'h1234));
    add("both_r_stb1",  bb, O(0,0,1,2'b00,0,0,0,16'h0041,16'h0,16'h5A2D,16'h1234));
    add("both_r_stb2",  bb, O(0,0,1,2'b00,0,0,0,16'h0041,16'h0,16'h5A2D,16'h1234));
    add("both_r_hold",  bb, O(0,1,1,2'b00,0,0,1,16'h0041,16'h0,16'h5A2D,16'h5A1B));
    add("both_r_done",  bb, I(16'h5A2D, 16'h5A1B));
    add("both_m_setup", mo, O(0,1,1,2'b00,0,0,0,16'h0010,16'h0,16'h5A2D,16'h5A1B));
    add("both_m_stb1",  mo, O(0,0,1,2'b00,0,0,0,16'h0010,16'h0,16'h5A2D,16'h5A1B));
    add("both_m_stb2",  mo, O(0,0,1,2'b00,0,0,0,16'h0010,16'h0,16'h5A2D,16'h5A1B));
    add("both_m_hold",  mo, O(0,1,1,2'b00,0,1,0,16'h0010,16'h0,16'h5A4A,16'h5A1B));
    add("both_m_done",  mo, I(16'h5A4A, 16'h5A1B));
    add("both_idle",    q,  I(16'h5A4A, 16'h5A1B));

    add("ab_setup", w,  O(0,1,1,2'b00,1,0,0,16'h0123,16'hBEEF,16'h5A4A,16'h5A1B));
    add("ab_stb1",  w,  O(0,1,0,2'b00,1,0,0,16'h0123,16'hBEEF,16'h5A4A,16'h5A1B));
    add("ab_stb2",  w,  O(0,1,0,2'b00,1,0,0,16'h0123,16'hBEEF,16'h5A4A,16'h5A1B));
    add("ab_reset", rw, I(0, 0), 1);
    add("ab_noack1", q, I(0, 0));
    add("ab_noack2", q, I(0, 0));
    ren_seq("fresh", 16'h0);
    add("fresh_idle", q, I(0, 16'h1234));
  endtask

  task automatic run_burst();
    int          acks;
    int          viol;
    logic [1:0]  who [18];
    int          at [18];
    logic [1:0]  ew;
    acks = 0;
    viol = 0;
    reset = 0;
    mpu_req = 1; mpu_wr = 0; mpu_be = 2'b11;
    mpu_addr = 16'h0300; mpu_wdata = 16'h0;
    ren_req = 1; ren_addr = 16'h0050;
    for (int c = 1; c <= 200 && acks < 18; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!_vram_rd && !_vram_wr) viol++;
      if (mpu_ack && ren_ack) viol++;
      if (mpu_ack || ren_ack) begin
        who[acks] = {mpu_ack, ren_ack};
        at[acks] = c;
        acks++;
      end
    end
    nvec++;
    if (acks != 18) begin
      nbad++;
      $display("FAIL burst_count got=%0d exp=18", acks);
    end
    for (int k = 0; k < acks; k++) begin
      ew = (k % 9 == 8) ? 2'b10 : 2'b01;
      nvec++;
      if (who[k] !== ew || at[k] != 4 + 5 * k) begin
        nbad++;
        $display("FAIL burst_ack%0d got=%b@%0d exp=%b@%0d",
                 k, who[k], at[k], ew, 4 + 5 * k);
      end
    end
    nvec++;
    if (viol != 0) begin
      nbad++;
      $display("FAIL burst_excl got=%0d exp=0", viol);
    end
    mpu_req = 0;
    ren_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("burst_end", I(16'h595A, 16'h5A0A));
  endtask

  initial begin
    build();
    foreach (tbl[i]) begin
      drive(tbl[i].s);
      @(posedge clk);
      @(negedge clk);
      chk(tbl[i].name, tbl[i].e);
      if (tbl[i].cs) begin
        nvec++;
        if (stat_mpu_stall !== 16'h0) begin
          nbad++;
          $display("FAIL %s_stat got=%h exp=0000",
                   tbl[i].name, stat_mpu_stall);
        end
      end
    end
    run_burst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
